fp_adder: RTL and testbench

- IEEE-754 single-precision (binary32) adder: sum = n1 + n2.
- Two-stage pipeline: stage 1 unpacks, orders and aligns; stage 2 adds/subtracts, normalizes, rounds and packs.
- Used as the arithmetic leaf of the datapath's floating-point unit; operand order must never affect the result.

---
 rtl/fp32_pkg.sv | 46 ++++
 rtl/fp_lzc.sv | 25 ++
 rtl/fp_adder.sv | 165 ++++++++++++++++
 tb/tb_fp_adder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
`default_nettype none
//============================================================================
// Module   : fp32_pkg
// Desc     : binary32 field widths, special encodings and the pipeline record
// Revision : 1.0  initial release
//============================================================================
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int SIG_W  = FRAC_W + 1;   // significand with hidden bit
    localparam int EXT_W  = SIG_W + 3;    // significand plus guard, round, sticky

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic              special;
        logic [31:0]       special_val;
        logic              sign;
        logic              sub;
        logic [EXP_W-1:0]  exp;
        logic [SIG_W-1:0]  sig_a;
        logic [EXT_W-1:0]  sig_b;
    } s1_rec_t;

    // Subnormals are treated as zero of the same sign.
    function automatic fp32_t flush_sub(input fp32_t x);
        fp32_t y;
        y = x;
        if (x.exp == '0) begin
            y.frac = '0;
        end
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
//============================================================================
// Module   : fp_lzc
// Desc     : 27-bit leading-zero counter (returns 27 for an all-zero input)
// Revision : 1.0  initial release
//============================================================================
module fp_lzc
    import fp32_pkg::*;
(
    input  logic [EXT_W-1:0] val,
    output logic [4:0]       cnt
);

    // Scanning upward lets the most significant set bit win.
    always_comb begin
        cnt = 5'(EXT_W);
        for (int i = 0; i < EXT_W; i++) begin
            if (val[i]) begin
                cnt = 5'(EXT_W - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_adder.sv
`default_nettype none
//============================================================================
// Module   : fp_adder
// Desc     : pipelined binary32 adder, RNE, flush-to-zero, two-cycle latency
// Revision : 1.0  initial release
//============================================================================
module fp_adder
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] n1,
    input  logic [31:0] n2,
    output logic        out_valid,
    output logic [31:0] sum
);

    logic                r_in_valid;
    logic [31:0]         r_n1;
    logic [31:0]         r_n2;

    fp32_t               w_x;
    fp32_t               w_y;
    fp32_t               w_a;
    fp32_t               w_b;
    logic                w_swap;
    logic                w_nan;
    logic [EXP_W-1:0]    w_ediff;
    logic [4:0]          w_shamt;
    logic [SIG_W-1:0]    w_sig_a;
    logic [SIG_W-1:0]    w_sig_b;
    logic [SIG_W+25:0]   w_shifted;
    s1_rec_t             w_s1;
    s1_rec_t             r_s1;
    logic                r_s1_valid;

    logic [EXT_W:0]      w_add;
    logic [EXT_W-1:0]    w_sub_res;
    logic [EXT_W-1:0]    w_m;
    logic [4:0]          w_lz;
    logic signed [9:0]   w_e;
    logic signed [9:0]   w_er;
    logic                w_zero;
    logic                w_round_up;
    logic [SIG_W:0]      w_rsig;
    logic [FRAC_W-1:0]   w_frac;
    logic [31:0]         w_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid <= 1'b0;
        end else begin
            r_in_valid <= in_valid;
        end
        if (in_valid) begin
            r_n1 <= n1;
            r_n2 <= n2;
        end
    end

    // Stage 1: unpack, order by magnitude, align the smaller operand.
    assign w_x    = flush_sub(fp32_t'(r_n1));
    assign w_y    = flush_sub(fp32_t'(r_n2));
    assign w_swap = {w_y.exp, w_y.frac} > {w_x.exp, w_x.frac};
    assign w_a    = w_swap ? w_y : w_x;
    assign w_b    = w_swap ? w_x : w_y;
    assign w_nan  = ((w_x.exp == 8'hFF) && (w_x.frac != '0)) ||
                    ((w_y.exp == 8'hFF) && (w_y.frac != '0));

    assign w_sig_a   = {w_a.exp != '0, w_a.frac};
    assign w_sig_b   = {w_b.exp != '0, w_b.frac};
    assign w_ediff   = w_a.exp - w_b.exp;
    assign w_shamt   = (w_ediff >= 8'd26) ? 5'd26 : w_ediff[4:0];
    assign w_shifted = {w_sig_b, 26'b0} >> w_shamt;

    always_comb begin
        w_s1.special     = (w_a.exp == 8'hFF);
        w_s1.special_val = w_a.sign ? NEG_INF : POS_INF;
        if (w_nan || ((w_b.exp == 8'hFF) && (w_a.sign != w_b.sign))) begin
            w_s1.special_val = QNAN;
        end
        w_s1.sign  = w_a.sign;
        w_s1.sub   = w_a.sign ^ w_b.sign;
        w_s1.exp   = w_a.exp;
        w_s1.sig_a = w_sig_a;
        w_s1.sig_b = {w_shifted[SIG_W+25:24], |w_shifted[23:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_in_valid;
        end
        if (r_in_valid) begin
            r_s1 <= w_s1;
        end
    end

    // Stage 2: add/subtract, normalize, round, pack.
    assign w_add     = {1'b0, r_s1.sig_a, 3'b000} + {1'b0, r_s1.sig_b};
    assign w_sub_res = {r_s1.sig_a, 3'b000} - r_s1.sig_b;

    fp_lzc u_lzc (
        .val (w_sub_res),
        .cnt (w_lz)
    );

    always_comb begin
        w_m    = '0;
        w_e    = '0;
        w_zero = 1'b0;
        if (r_s1.sub) begin
            w_m    = w_sub_res << w_lz;
            w_e    = 10'(r_s1.exp) - 10'(w_lz);
            w_zero = (w_sub_res == '0);
        end else if (w_add[EXT_W]) begin
            w_m    = {w_add[EXT_W:2], w_add[1] | w_add[0]};
            w_e    = 10'(r_s1.exp) + 10'sd1;
            w_zero = 1'b0;
        end else begin
            w_m    = w_add[EXT_W-1:0];
            w_e    = 10'(r_s1.exp);
            w_zero = (w_add == '0);
        end

        w_round_up = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
        w_rsig     = {1'b0, w_m[EXT_W-1:3]} + {{SIG_W{1'b0}}, w_round_up};
        if (w_rsig[SIG_W]) begin
            w_frac = w_rsig[FRAC_W:1];
            w_er   = w_e + 10'sd1;
        end else begin
            w_frac = w_rsig[FRAC_W-1:0];
            w_er   = w_e;
        end

        if (r_s1.special) begin
            w_result = r_s1.special_val;
        end else if (w_zero) begin
            // Exact cancellation is +0; only -0 + -0 keeps the sign.
            w_result = {r_s1.sign & ~r_s1.sub, 31'b0};
        end else if (w_e <= 10'sd0) begin
            w_result = {r_s1.sign, 31'b0};
        end else if (w_er >= 10'sd255) begin
            w_result = {r_s1.sign, 8'hFF, 23'b0};
        end else begin
            w_result = {r_s1.sign, w_er[7:0], w_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= 32'h0000_0000;
        end else begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                sum <= w_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_adder.sv
`default_nettype none
//============================================================================
// Module   : tb_fp_adder
// Desc     : self-checking bench for fp_adder against an exact-integer model
// Revision : 1.0  initial release
//============================================================================
module tb_fp_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] n1 = '0;
    logic [31:0] n2 = '0;
    logic        out_valid;
    logic [31:0] sum;

    fp_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .n1        (n1),
        .n2        (n2),
        .out_valid (out_valid),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          edge_no;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[$];
    int          cyc = 0;
    logic        last_rst = 1'b0;
    logic [31:0] last_sum = '0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        last_rst <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Exact value = significand * 2^(e-150); held as an integer in units of 2^-149.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] ia, ib, mag, rem, half, one;
        logic         sa, sb, sr, up;
        int           ea, eb, p, sh, e;
        logic [22:0]  fa, fb;
        logic [23:0]  keep;
        logic [24:0]  k25;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0]; fb = b[22:0];
        one = 300'd1;
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC0_0000;
        if (ea == 255 && eb == 255) return (sa == sb) ? a : 32'h7FC0_0000;
        if (ea == 255) return a;
        if (eb == 255) return b;
        ia = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 1));
        ib = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 1));
        if (sa == sb) begin
            mag = ia + ib; sr = sa;
        end else if (ia >= ib) begin
            mag = ia - ib; sr = sa;
        end else begin
            mag = ib - ia; sr = sb;
        end
        if (mag == '0) return {sa & sb, 31'b0};
        p = -1;
        for (int i = 299; i >= 0 && p < 0; i--) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) return {sr, 31'b0};
        sh = p - 23;
        keep = 24'(mag >> sh);
        up = 1'b0;
        if (sh > 0) begin
            rem  = mag & ((one << sh) - one);
            half = one << (sh - 1);
            up   = (rem > half) || (rem == half && keep[0]);
        end
        k25 = {1'b0, keep} + 25'(up);
        if (k25[24]) begin
            e++;
            keep = k25[24:1];
        end else begin
            keep = k25[23:0];
        end
        if (e >= 255) return {sr, 8'hFF, 23'b0};
        return {sr, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp(input int near_exp);
        int          k, ex;
        logic        s;
        logic [22:0] f;
        k = $urandom_range(0, 99);
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        if (k < 4)  return {s, 31'b0};
        if (k < 7)  return {s, 8'h00, f | 23'd1};
        if (k < 10) return {s, 8'hFF, 23'b0};
        if (k < 12) return {s, 8'hFF, f | 23'd1};
        if (near_exp < 0) begin
            ex = $urandom_range(1, 254);
        end else begin
            ex = near_exp + int'($urandom_range(0, 6)) - 3;
            if (ex < 1)   ex = 1;
            if (ex > 254) ex = 254;
        end
        return {s, 8'(ex), f};
    endfunction

    // Output monitor: checks latency, data, hold behaviour and reset state.
    always @(negedge clk) begin
        logic expv;
        if (last_rst) begin
            check("reset out_valid", {31'b0, out_valid}, 32'd0);
            check("reset sum", sum, 32'h0);
            q.delete();
            last_sum = 32'h0;
        end else begin
            expv = (q.size() > 0) && (q[0].edge_no + 2 == cyc);
            check("out_valid", {31'b0, out_valid}, {31'b0, expv});
            if (expv) begin
                check("sum", sum, q[0].val);
                last_sum = q[0].val;
                void'(q.pop_front());
            end else begin
                check("sum hold", sum, last_sum);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        n1 = a;
        n2 = b;
        in_valid = 1'b1;
        q.push_back('{val: res, edge_no: cyc + 1});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back('{32'h41C1_0000, 32'h446C_B000, 32'h4472_B800});
        vecs.push_back('{32'h446C_B000, 32'h41C1_0000, 32'h4472_B800});
        vecs.push_back('{32'h3DCC_CCCD, 32'h3ECC_CCCD, 32'h3F00_0000});
        vecs.push_back('{32'h4088_0000, 32'hC084_0000, 32'h3E00_0000});
        vecs.push_back('{32'hC084_0000, 32'h4088_0000, 32'h3E00_0000});
        vecs.push_back('{32'hC102_0000, 32'h4088_0000, 32'hC078_0000});
        vecs.push_back('{32'hC2F5_4000, 32'h430E_8000, 32'h419F_0000});
        vecs.push_back('{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000});
        vecs.push_back('{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000});
        vecs.push_back('{32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000});
        vecs.push_back('{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000});
        vecs.push_back('{32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000});
        vecs.push_back('{32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000});
        vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'h8000_0000});
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{32'h8040_0000, 32'h8000_0000, 32'h8000_0000});
        vecs.push_back('{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000});
        vecs.push_back('{32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002});
        vecs.push_back('{32'h4B7F_FFFF, 32'h3F80_0000, 32'h4B80_0000});
        vecs.push_back('{32'h3F80_0000, 32'hBF7F_FFFF, 32'h3380_0000});
        vecs.push_back('{32'h8080_0001, 32'h0080_0000, 32'h8000_0000});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Isolated operation: out_valid must rise exactly two edges after sampling.
        issue(32'h41C1_0000, 32'h446C_B000, 32'h4472_B800);
        idle(4);

        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].res);
        idle(3);

        // Specials streamed back-to-back.
        issue(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        issue(32'h4000_0000, 32'hC000_0000, 32'h0000_0000);
        idle(3);

        // Reset with two operations in flight: both must be discarded.
        issue(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(5);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            if ($urandom_range(0, 3) == 0) idle(1);
            a = rand_fp(-1);
            b = rand_fp(($urandom_range(0, 1) == 1) ? int'(a[30:23]) : -1);
            issue(a, b, ref_add(a, b));
            if (i % 4 == 0) issue(b, a, ref_add(a, b));
        end

        idle(6);
        check("queue drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
